firengine_coef_loader: RTL and testbench
========================================

Name: firengine_coef_loader

Overview:
- Sequences run-time coefficient updates into a firengine coefficient buffer.
- Accepts a host command (base address, length) followed by a valid/ready stream of 18-bit coefficients.
- Buffers the words in a small FIFO and issues single-cycle writes on the engine's coefficient write port, only while the timeslice sequencer asserts iWrAllow.
- Sits between the host/config bus and one firengine instance; one loader per engine.

Parameters:
ADDR_W, 8, coefficient buffer address width (buffer wraps at 2**ADDR_W).
DATA_W, 18, coefficient word width.
LOG2FIFO, 2, log2 depth of the internal word FIFO (default 4 entries).

Ports:
iClk  in  1  timeslice clock
iRst  in  1  asynchronous reset, active-high
iCmdValid  in  1  command present
oCmdReady  out  1  command accepted when iCmdValid && oCmdReady
iCmdBase  in  ADDR_W  first coefficient address
iCmdLen  in  ADDR_W+1  number of words, 1..2**ADDR_W; 0 is illegal
iDataValid  in  1  coefficient word present
oDataReady  out  1  word accepted when iDataValid && oDataReady
iData  in  DATA_W  coefficient word
iWrAllow  in  1  write window from timeslice sequencer
iAbort  in  1  cancel current load
oCoefBuff_wren  out  1  write strobe to engine
oCoefBuff_wraddr  out  ADDR_W  write address
oCoefBuff_wrdata  out  DATA_W  write data
oBusy  out  1  high in any state other than IDLE
oDone  out  1  one-cycle pulse, load completed
oError  out  1  one-cycle pulse, load rejected or aborted
oWrCount  out  ADDR_W+1  words written in current/last load

Behaviour:
- Reset (async, iRst=1): state IDLE, FIFO empty, all counters 0, all outputs 0. A reset mid-load discards the load and produces no oDone or oError.
- States: IDLE, LOAD, DRAIN, DONE, ERR.
- IDLE:
  - oCmdReady=1, oDataReady=0.
  - On command handshake, latch base/len, clear the accepted and written counters and oWrCount.
  - iCmdLen==0 -> ERR. Otherwise -> LOAD.
- LOAD:
  - oDataReady = FIFO not full && accepted < len.
  - When accepted reaches len -> DRAIN. The LOAD->DRAIN transition is taken in the cycle after the last data handshake.
- DRAIN: no data accepted. When written == len -> DONE.
- Write issue, in LOAD or DRAIN:
  - Each cycle where FIFO non-empty && iWrAllow && !iAbort, pop one word.
  - Next cycle, oCoefBuff_wren=1 with wraddr = (base + written) mod 2**ADDR_W and wrdata = the popped word.
  - All three write outputs are registered; wren is 0 otherwise. wraddr and wrdata hold their last values when wren=0.
  - oWrCount increments with each wren.
- Latency: a word accepted in cycle N with the FIFO empty and iWrAllow high at N+1 appears on wren at N+2. There is no fall-through.
- Simultaneous push and pop on a full FIFO is legal.
- Simultaneous push and pop on an empty FIFO: the pop is not permitted in the same cycle.
- Address wrap: base=0xFE, len=4 writes 0xFE, 0xFF, 0x00, 0x01.
- DONE: oDone=1 for one cycle -> IDLE.
- ERR: oError=1 for one cycle, FIFO flushed -> IDLE. No writes are issued in ERR.
- iAbort, sampled in LOAD or DRAIN:
  - No pop or wren is generated from that cycle on.
  - Go to ERR. A write already registered in the previous cycle still completes.
  - iAbort in IDLE is ignored.
- iCmdValid is ignored outside IDLE; commands are never queued.
- iWrAllow held low stalls writes indefinitely without data loss. Backpressure reaches the host through oDataReady once the FIFO fills.

Decomposition:
- Shared package firengine_pkg holds:
  - the state enumeration (IDLE, LOAD, DRAIN, DONE, ERR);
  - the default widths COEF_ADDR_W=8 and COEF_DATA_W=18, shared with firengine's coefficient port.
- One sub-module: firengine_coef_fifo, a synchronous FIFO with push/pop/full/empty/flush and a 1-cycle registered read.

Test Plan:
- Basic load: base=0x00, len=8, words 0x004000, 0x008000, 0x004000, 0, 0, 0, 0, 0x008000, iWrAllow=1 -> 8 wren at addresses 0..7 with matching data in order; oDone pulses once, 1 cycle after the last wren; oWrCount=8.
- Write gating: iWrAllow high 1 cycle in 32, len=4 -> exactly one wren per allow window; oDataReady drops after 4 buffered words; no word lost or duplicated.
- Wrap: base=0xFE, len=4 -> wraddr sequence 0xFE, 0xFF, 0x00, 0x01; oDone pulses once.
- Illegal length: iCmdLen=0 -> no wren; oError pulses once; oCmdReady returns high 2 cycles after the command.
- Abort: len=16, iAbort asserted after the 5th wren -> at most 6 wrens total; oError pulses once; no oDone; a following len=2 command loads correctly from empty.
- Reset mid-load: iRst asserted during DRAIN -> all outputs 0 immediately; no oDone or oError; the next command behaves as from power-up.

Source files
------------

// File: rtl/firengine_pkg.sv
// firengine_pkg
// Shared definitions for the firengine coefficient path: the coefficient
// port widths (also used by the engine's coefficient buffer) and the
// coefficient loader state encoding.
package firengine_pkg;

    localparam int COEF_ADDR_W = 8;
    localparam int COEF_DATA_W = 18;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        DRAIN,
        DONE,
        ERR
    } coef_ld_state_e;

endpackage

// File: rtl/firengine_coef_fifo.sv
// firengine_coef_fifo
// Small synchronous word FIFO with a registered read port: a pop in cycle N
// presents the popped word on oPopData in cycle N+1, and the value holds
// until the next pop. There is no fall-through, so a word pushed into an
// empty FIFO cannot be popped in the same cycle.
// Ports:
//   iClk, iRst     clock, asynchronous active-high reset
//   iPush/iPushData write side (ignored when full unless popping too)
//   iPop           read request (ignored when empty)
//   iFlush         discard all contents; wins over push and pop
//   oPopData       registered read data
//   oFull, oEmpty  occupancy flags
module firengine_coef_fifo #(
    parameter int DATA_W   = 18,
    parameter int LOG2FIFO = 2
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic              iPush,
    input  logic [DATA_W-1:0] iPushData,
    input  logic              iPop,
    input  logic              iFlush,
    output logic [DATA_W-1:0] oPopData,
    output logic              oFull,
    output logic              oEmpty
);

    localparam int DEPTH = 1 << LOG2FIFO;

    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic [LOG2FIFO-1:0] wptr_q, rptr_q;
    logic [LOG2FIFO:0]   cnt_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                do_push, do_pop;

    assign oFull    = (cnt_q == (LOG2FIFO+1)'(DEPTH));
    assign oEmpty   = (cnt_q == '0);
    assign oPopData = rdata_q;

    // A full FIFO still accepts a push when a pop frees the slot in the same
    // cycle; the read below sees the old entry because both are registered.
    assign do_pop  = iPop && !oEmpty && !iFlush;
    assign do_push = iPush && (!oFull || do_pop) && !iFlush;

    always_ff @(posedge iClk) begin
        if (do_push) mem_q[wptr_q] <= iPushData;
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
        end else if (iFlush) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + LOG2FIFO'(1);
            if (do_pop) begin
                rptr_q  <= rptr_q + LOG2FIFO'(1);
                rdata_q <= mem_q[rptr_q];
            end
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + (LOG2FIFO+1)'(1);
                2'b01:   cnt_q <= cnt_q - (LOG2FIFO+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/firengine_coef_loader.sv
// firengine_coef_loader
// Sequences a run-time coefficient update into one firengine coefficient
// buffer. A host command (base, len) opens a load; len coefficient words are
// then taken from a valid/ready stream, buffered in a small FIFO and written
// one per cycle to the engine while the timeslice sequencer grants iWrAllow.
// Ports:
//   iClk, iRst                 clock, asynchronous active-high reset
//   iCmdValid/oCmdReady        command handshake, iCmdBase / iCmdLen payload
//   iDataValid/oDataReady      coefficient stream handshake, iData payload
//   iWrAllow                   write window from the timeslice sequencer
//   iAbort                     cancel the current load
//   oCoefBuff_wren/wraddr/wrdata registered write port to the engine
//   oBusy, oDone, oError       status; oDone/oError are one-cycle pulses
//   oWrCount                   words written in the current/last load
module firengine_coef_loader
    import firengine_pkg::*;
#(
    parameter int ADDR_W   = COEF_ADDR_W,
    parameter int DATA_W   = COEF_DATA_W,
    parameter int LOG2FIFO = 2
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic              iCmdValid,
    output logic              oCmdReady,
    input  logic [ADDR_W-1:0] iCmdBase,
    input  logic [ADDR_W:0]   iCmdLen,
    input  logic              iDataValid,
    output logic              oDataReady,
    input  logic [DATA_W-1:0] iData,
    input  logic              iWrAllow,
    input  logic              iAbort,
    output logic              oCoefBuff_wren,
    output logic [ADDR_W-1:0] oCoefBuff_wraddr,
    output logic [DATA_W-1:0] oCoefBuff_wrdata,
    output logic              oBusy,
    output logic              oDone,
    output logic              oError,
    output logic [ADDR_W:0]   oWrCount
);

    coef_ld_state_e    state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [ADDR_W:0]   acc_q, acc_d;   // words accepted from the host
    logic [ADDR_W:0]   wr_q, wr_d;     // words written (counts with wren)
    logic              wren_q, wren_d;
    logic [ADDR_W-1:0] wraddr_q, wraddr_d;

    logic fifo_full, fifo_empty;
    logic push, pop, flush, data_rdy, active;

    assign active   = (state_q == LOAD) || (state_q == DRAIN);
    assign data_rdy = (state_q == LOAD) && !fifo_full && (acc_q < len_q);
    assign push     = iDataValid && data_rdy;
    // fifo_empty is registered, so a word pushed this cycle is not yet
    // poppable: that is what gives the two-cycle accept-to-write latency.
    assign pop      = active && !fifo_empty && iWrAllow && !iAbort;
    assign flush    = (state_q == ERR);

    firengine_coef_fifo #(
        .DATA_W   (DATA_W),
        .LOG2FIFO (LOG2FIFO)
    ) u_fifo (
        .iClk      (iClk),
        .iRst      (iRst),
        .iPush     (push),
        .iPushData (iData),
        .iPop      (pop),
        .iFlush    (flush),
        .oPopData  (oCoefBuff_wrdata),
        .oFull     (fifo_full),
        .oEmpty    (fifo_empty)
    );

    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        len_d    = len_q;
        acc_d    = acc_q;
        wr_d     = wr_q;
        wraddr_d = wraddr_q;
        wren_d   = pop;

        if (push) acc_d = acc_q + (ADDR_W+1)'(1);
        // wr_q is bumped together with the registered wren, so its value at
        // pop time is exactly the offset of the word being popped.
        if (pop) begin
            wr_d     = wr_q + (ADDR_W+1)'(1);
            wraddr_d = base_q + wr_q[ADDR_W-1:0];
        end

        case (state_q)
            IDLE: begin
                if (iCmdValid) begin
                    base_d  = iCmdBase;
                    len_d   = iCmdLen;
                    acc_d   = '0;
                    wr_d    = '0;
                    state_d = (iCmdLen == '0) ? ERR : LOAD;
                end
            end
            LOAD: begin
                if (iAbort)              state_d = ERR;
                else if (acc_q == len_q) state_d = DRAIN;
            end
            DRAIN: begin
                if (iAbort)             state_d = ERR;
                else if (wr_q == len_q) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_q  <= IDLE;
            base_q   <= '0;
            len_q    <= '0;
            acc_q    <= '0;
            wr_q     <= '0;
            wren_q   <= 1'b0;
            wraddr_q <= '0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            len_q    <= len_d;
            acc_q    <= acc_d;
            wr_q     <= wr_d;
            wren_q   <= wren_d;
            wraddr_q <= wraddr_d;
        end
    end

    // Command ready is masked during reset so every output reads 0 there.
    assign oCmdReady        = (state_q == IDLE) && !iRst;
    assign oDataReady       = data_rdy;
    assign oCoefBuff_wren   = wren_q;
    assign oCoefBuff_wraddr = wraddr_q;
    assign oBusy            = (state_q != IDLE);
    assign oDone            = (state_q == DONE);
    assign oError           = (state_q == ERR);
    assign oWrCount         = wr_q;

endmodule

// File: tb/tb_firengine_coef_loader.sv
module tb_firengine_coef_loader;

    logic        iClk = 1'b0;
    logic        iRst = 1'b1;
    logic        iCmdValid = 1'b0;
    logic        oCmdReady;
    logic [7:0]  iCmdBase = '0;
    logic [8:0]  iCmdLen = '0;
    logic        iDataValid = 1'b0;
    logic        oDataReady;
    logic [17:0] iData = '0;
    logic        iWrAllow = 1'b0;
    logic        iAbort = 1'b0;
    logic        oCoefBuff_wren;
    logic [7:0]  oCoefBuff_wraddr;
    logic [17:0] oCoefBuff_wrdata;
    logic        oBusy, oDone, oError;
    logic [8:0]  oWrCount;

    firengine_coef_loader dut (
        .iClk(iClk), .iRst(iRst),
        .iCmdValid(iCmdValid), .oCmdReady(oCmdReady),
        .iCmdBase(iCmdBase), .iCmdLen(iCmdLen),
        .iDataValid(iDataValid), .oDataReady(oDataReady), .iData(iData),
        .iWrAllow(iWrAllow), .iAbort(iAbort),
        .oCoefBuff_wren(oCoefBuff_wren), .oCoefBuff_wraddr(oCoefBuff_wraddr),
        .oCoefBuff_wrdata(oCoefBuff_wrdata),
        .oBusy(oBusy), .oDone(oDone), .oError(oError), .oWrCount(oWrCount)
    );

    always #5 iClk = ~iClk;

    int n_vec = 0;
    int n_err = 0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endfunction

    // Observer: records every write and status pulse with its cycle number.
    int          cyc = 0;
    logic [7:0]  obs_addr[$];
    logic [17:0] obs_data[$];
    int          obs_cyc[$];
    int          done_cnt = 0, err_cnt = 0, done_cyc = 0;

    always @(negedge iClk) begin
        cyc++;
        if (oCoefBuff_wren) begin
            obs_addr.push_back(oCoefBuff_wraddr);
            obs_data.push_back(oCoefBuff_wrdata);
            obs_cyc.push_back(cyc);
        end
        if (oDone) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (oError) err_cnt++;
    end

    // allow_mode: 0 low, 1 always high, 255 random, otherwise 1-in-N period
    int allow_mode = 1;
    logic [17:0] wbuf[$];
    int q0_g, d0_g, e0_g;

    typedef struct {
        logic [7:0] base;
        logic [8:0] len;
        int         allow;
        bit         gap;
        bit         exp_stall;
    } vec_t;

    task automatic snap();
        q0_g = obs_addr.size();
        d0_g = done_cnt;
        e0_g = err_cnt;
    endtask

    task automatic issue_cmd(input logic [7:0] base, input logic [8:0] len);
        int b = 0;
        while (!oCmdReady && b < 1000) begin
            @(negedge iClk); #1; b++;
        end
        if (b >= 1000) chk("cmd_ready_timeout", 0, 1);
        iCmdValid = 1'b1;
        iCmdBase  = base;
        iCmdLen   = len;
        @(negedge iClk); #1;
        iCmdValid = 1'b0;
        iCmdBase  = 8'($urandom);
        iCmdLen   = 9'($urandom);
    endtask

    task automatic feed(input int n, input bit gap, input int abort_after,
                        output int stall, output int hs0);
        int e0 = err_cnt;
        stall = 0;
        hs0   = -1;
        fork
            begin
                int i = 0;
                int b = 0;
                while (i < n && err_cnt == e0 && b < 5000) begin
                    iDataValid = gap ? ($urandom_range(3) != 0) : 1'b1;
                    iData      = iDataValid ? wbuf[i] : 18'($urandom);
                    if (iDataValid && oDataReady) begin
                        if (i == 0) hs0 = cyc;
                        i++;
                    end else if (!oDataReady && oBusy) begin
                        stall++;
                    end
                    @(negedge iClk); #1; b++;
                end
                iDataValid = 1'b0;
                if (b >= 5000) chk("feed_timeout", 0, 1);
            end
            begin
                if (abort_after > 0) begin
                    int wc = 0;
                    int b2 = 0;
                    while (wc < abort_after && b2 < 5000) begin
                        @(negedge iClk); #1; b2++;
                        if (oCoefBuff_wren) wc++;
                    end
                    if (b2 >= 5000) chk("abort_wait_timeout", 0, 1);
                    iAbort = 1'b1;
                    @(negedge iClk); #1;
                    iAbort = 1'b0;
                end
            end
        join
    endtask

    task automatic wait_end();
        int b = 0;
        while (done_cnt == d0_g && err_cnt == e0_g && b < 3000) begin
            @(negedge iClk); #1; b++;
        end
        if (b >= 3000) chk("end_timeout", 0, 1);
        repeat (3) begin
            @(negedge iClk); #1;
        end
    endtask

    task automatic run_load(input logic [7:0] base, input logic [8:0] len, input bit gap,
                            output int stall, output int hs0);
        snap();
        issue_cmd(base, len);
        feed(int'(len), gap, 0, stall, hs0);
        wait_end();
    endtask

    // Reference: word i of a load lands at (base + i) mod 256, in order,
    // exactly len writes, one done pulse one cycle after the last write.
    task automatic check_load(input logic [7:0] base, input logic [8:0] len, input bit chk_gap);
        int n = obs_addr.size() - q0_g;
        int mingap = 1 << 30;
        chk("wren_count", n, len);
        for (int i = 0; i < n && i < int'(len); i++) begin
            chk("wraddr", obs_addr[q0_g+i], 32'((int'(base) + i) % 256));
            chk("wrdata", obs_data[q0_g+i], wbuf[i]);
        end
        chk("done_pulses", done_cnt - d0_g, 1);
        chk("err_pulses", err_cnt - e0_g, 0);
        chk("wrcount", oWrCount, len);
        if (n > 0) chk("done_timing", done_cyc, obs_cyc[q0_g+n-1] + 1);
        if (chk_gap && n > 1) begin
            for (int i = 1; i < n; i++)
                if (obs_cyc[q0_g+i] - obs_cyc[q0_g+i-1] < mingap)
                    mingap = obs_cyc[q0_g+i] - obs_cyc[q0_g+i-1];
            chk("one_wren_per_window", mingap >= 32, 1);
        end
    endtask

    initial begin
        fork
            begin
                int gc = 0;
                forever begin
                    @(negedge iClk);
                    gc++;
                    case (allow_mode)
                        0:       iWrAllow = 1'b0;
                        1:       iWrAllow = 1'b1;
                        255:     iWrAllow = 1'($urandom_range(1));
                        default: iWrAllow = (gc % allow_mode == 0);
                    endcase
                end
            end
        join_none
    end

    initial begin
        vec_t tbl[7];
        int stall, hs0, n;
        logic [7:0] rb;
        logic [8:0] rl;
        bit rg;
        int pick;

        tbl[0] = '{8'h00, 9'd8,   1,   1'b0, 1'b0};
        tbl[1] = '{8'h10, 9'd4,   32,  1'b0, 1'b0};
        tbl[2] = '{8'h20, 9'd8,   32,  1'b0, 1'b1};
        tbl[3] = '{8'hFE, 9'd4,   1,   1'b0, 1'b0};
        tbl[4] = '{8'h80, 9'd256, 1,   1'b1, 1'b0};
        tbl[5] = '{8'h05, 9'd1,   1,   1'b0, 1'b0};
        tbl[6] = '{8'hFF, 9'd2,   255, 1'b1, 1'b0};

        // reset state
        #2;
        chk("rst_wren", oCoefBuff_wren, 0);
        chk("rst_busy", oBusy, 0);
        chk("rst_done", oDone, 0);
        chk("rst_error", oError, 0);
        chk("rst_wrcount", oWrCount, 0);
        chk("rst_cmdready", oCmdReady, 0);
        chk("rst_dataready", oDataReady, 0);
        repeat (2) @(negedge iClk);
        #1 iRst = 1'b0;
        @(negedge iClk); #1;
        chk("idle_cmdready", oCmdReady, 1);

        // table-driven loads
        for (int v = 0; v < 7; v++) begin
            allow_mode = tbl[v].allow;
            wbuf.delete();
            if (v == 0) begin
                wbuf = '{18'h04000, 18'h08000, 18'h04000, 18'h0, 18'h0, 18'h0, 18'h0, 18'h08000};
            end else begin
                for (int i = 0; i < int'(tbl[v].len); i++) wbuf.push_back(18'($urandom));
            end
            run_load(tbl[v].base, tbl[v].len, tbl[v].gap, stall, hs0);
            check_load(tbl[v].base, tbl[v].len, tbl[v].allow == 32);
            if (v == 0) chk("first_write_latency", obs_cyc[q0_g], hs0 + 2);
            if (tbl[v].exp_stall) chk("backpressure", stall > 0, 1);
            if (v == 0 || v == 3) chk("idle_after_done", oCmdReady, 1);
        end

        // illegal length
        allow_mode = 1;
        snap();
        issue_cmd(8'h11, 9'd0);
        chk("len0_error", oError, 1);
        chk("len0_cmdready_low", oCmdReady, 0);
        @(negedge iClk); #1;
        chk("len0_cmdready_back", oCmdReady, 1);
        chk("len0_error_one_cycle", oError, 0);
        repeat (3) begin @(negedge iClk); #1; end
        chk("len0_no_wren", obs_addr.size() - q0_g, 0);
        chk("len0_err_pulses", err_cnt - e0_g, 1);
        chk("len0_done_pulses", done_cnt - d0_g, 0);

        // abort after the 5th write
        wbuf.delete();
        for (int i = 0; i < 16; i++) wbuf.push_back(18'($urandom));
        snap();
        issue_cmd(8'h50, 9'd16);
        feed(16, 1'b0, 5, stall, hs0);
        wait_end();
        n = obs_addr.size() - q0_g;
        chk("abort_wrens_min", n >= 5, 1);
        chk("abort_wrens_max", n <= 6, 1);
        for (int i = 0; i < n; i++) begin
            chk("abort_wraddr", obs_addr[q0_g+i], 32'((8'h50 + i) % 256));
            chk("abort_wrdata", obs_data[q0_g+i], wbuf[i]);
        end
        chk("abort_err_pulses", err_cnt - e0_g, 1);
        chk("abort_done_pulses", done_cnt - d0_g, 0);
        chk("abort_wrcount", oWrCount, n);
        wbuf.delete();
        wbuf = '{18'h2AAAA, 18'h15555};
        run_load(8'h40, 9'd2, 1'b0, stall, hs0);
        check_load(8'h40, 9'd2, 1'b0);

        // reset while draining
        allow_mode = 0;
        wbuf.delete();
        for (int i = 0; i < 4; i++) wbuf.push_back(18'($urandom));
        snap();
        issue_cmd(8'h30, 9'd4);
        feed(4, 1'b0, 0, stall, hs0);
        repeat (2) begin @(negedge iClk); #1; end
        chk("pre_rst_busy", oBusy, 1);
        iRst = 1'b1;
        #1;
        chk("mid_rst_wren", oCoefBuff_wren, 0);
        chk("mid_rst_wraddr", oCoefBuff_wraddr, 0);
        chk("mid_rst_wrdata", oCoefBuff_wrdata, 0);
        chk("mid_rst_busy", oBusy, 0);
        chk("mid_rst_done", oDone, 0);
        chk("mid_rst_error", oError, 0);
        chk("mid_rst_wrcount", oWrCount, 0);
        chk("mid_rst_cmdready", oCmdReady, 0);
        chk("mid_rst_dataready", oDataReady, 0);
        @(negedge iClk); #1;
        iRst = 1'b0;
        allow_mode = 1;
        repeat (5) begin @(negedge iClk); #1; end
        chk("post_rst_no_done", done_cnt - d0_g, 0);
        chk("post_rst_no_error", err_cnt - e0_g, 0);
        chk("post_rst_no_wren", obs_addr.size() - q0_g, 0);
        wbuf.delete();
        wbuf = '{18'h00123, 18'h3FFFF};
        run_load(8'h60, 9'd2, 1'b0, stall, hs0);
        check_load(8'h60, 9'd2, 1'b0);

        // randomized loads against the reference
        for (int r = 0; r < 16; r++) begin
            rb   = 8'($urandom);
            rl   = 9'($urandom_range(40, 1));
            rg   = 1'($urandom_range(1));
            pick = $urandom_range(2);
            allow_mode = (pick == 0) ? 1 : (pick == 1) ? 3 : 255;
            wbuf.delete();
            for (int i = 0; i < int'(rl); i++) wbuf.push_back(18'($urandom));
            run_load(rb, rl, rg, stall, hs0);
            check_load(rb, rl, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
